// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with B/H/W loads/stores and sign/zero extension.
// Define DMEM_RESPONDER_ERR_EN to flag misaligned accesses with err instead of forcing alignment.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW+1:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic we_q, we_d;
  logic [2:0] mode_q, mode_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW+1:0] x_a;
  logic [31:0] x_wd, wmask, lw, ld;
  logic [2:0] x_mode;
  logic x_we, sz_b, sz_h, sz_w, valid, mis, ok, commit;
  logic [1:0] off;
  logic [4:0] sh;
  logic [AW-1:0] idx;
  logic unused_hi;
  assign unused_hi = ^a[31:AW+2];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    wd_d    = wd_q;
    we_d    = we_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (req) begin
        a_d     = a[AW+1:0];
        wd_d    = wd;
        we_d    = we;
        mode_d  = mode;
        cnt_d   = LAT_M1;
        state_d = (LATENCY == 0) ? DONE : WAIT;
      end
      WAIT: begin
        state_d = (cnt_q == 4'd0) ? DONE : WAIT;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
    end
  end
  // In IDLE the live inputs drive decode so a zero-latency store commits at its acceptance edge.
  assign x_a    = (state_q == IDLE) ? a[AW+1:0] : a_q;
  assign x_wd   = (state_q == IDLE) ? wd : wd_q;
  assign x_we   = (state_q == IDLE) ? we : we_q;
  assign x_mode = (state_q == IDLE) ? mode : mode_q;
  assign sz_b   = x_mode[1:0] == 2'b00;
  assign sz_h   = x_mode[1:0] == 2'b01;
  assign sz_w   = x_mode == 3'b010;
  assign valid  = (x_mode[1:0] != 2'b11) & ~(x_mode[2] & x_mode[1]);
  assign mis    = (sz_h & x_a[0]) | (sz_w & |x_a[1:0]);
`ifdef DMEM_RESPONDER_ERR_EN
  assign off    = x_a[1:0];
  assign ok     = valid & ~mis;
`else
  assign off    = {x_a[1] & ~sz_w, x_a[0] & sz_b};
  assign ok     = valid;
`endif
  assign sh     = {off, 3'b000};
  assign idx    = x_a[AW+1:2];
  assign wmask  = (sz_w ? 32'hFFFF_FFFF : sz_h ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
  assign commit = reset & x_we & ok & (state_d == DONE);
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= (mem[idx] & ~wmask) | ((x_wd << sh) & wmask);
  end
  assign lw    = mem[idx] >> sh;
  assign ld    = sz_w ? lw
               : sz_h ? {{16{lw[15] & ~x_mode[2]}}, lw[15:0]}
               : {{24{lw[7] & ~x_mode[2]}}, lw[7:0]};
  assign ready = state_q == DONE;
  assign rd    = (ready & ~x_we & ok) ? ld : '0;
  assign busy  = req & ~ready;
`ifdef DMEM_RESPONDER_ERR_EN
  assign err   = ready & mis;
`else
  assign err   = 1'b0;
`endif
endmodule
